// File: rtl/ctrl_types_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_types_pkg
// Shared types for the cache controller command sequencer.
//   op_e         : host operation code (2 bits)
//   ctrl_state_e : top-level sequencer state
//   sub_cmd_t    : command word reported by each per-operation sub-FSM
// -----------------------------------------------------------------------------
package ctrl_types_pkg;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_GET = 2'd1,
      OP_PUT = 2'd2,
      OP_DEL = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      CTRL_ST_IDLE     = 2'd0,
      CTRL_ST_DISPATCH = 2'd1,
      CTRL_ST_WAIT     = 2'd2,
      CTRL_ST_RESP     = 2'd3
   } ctrl_state_e;

   // Sub-FSM command word; the sequencer only looks at .done.
   typedef struct packed {
      logic       done;
      logic       busy;
      logic [3:0] step;
   } sub_cmd_t;

   // Number of sub-FSMs; bit i of the per-sub vectors belongs to op code i+1.
   localparam int N_SUB = 3;

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm_if
// Bundles the host request/response handshakes and the three sub-FSM links.
//   master : the sequencer (drives req_ready, enter/en, resp_*, busy)
//   slave  : host + sub-FSMs (drive req_*, cmd/succ, resp_ready)
// -----------------------------------------------------------------------------
interface cache_ctrl_fsm_if;
   import ctrl_types_pkg::*;

   logic     req_valid;
   op_e      req_op;
   logic     req_ready;

   logic     get_enter, put_enter, del_enter;
   logic     get_en, put_en, del_en;
   sub_cmd_t get_cmd, put_cmd, del_cmd;
   logic     get_succ, put_succ, del_succ;

   logic     resp_valid;
   logic     resp_ready;
   op_e      resp_op;
   logic     resp_succ;
   logic     resp_err;
   logic     busy;

   modport master (
      input  req_valid, req_op,
      output req_ready,
      output get_enter, put_enter, del_enter,
      output get_en, put_en, del_en,
      input  get_cmd, put_cmd, del_cmd,
      input  get_succ, put_succ, del_succ,
      output resp_valid, resp_op, resp_succ, resp_err, busy,
      input  resp_ready
   );

   modport slave (
      output req_valid, req_op,
      input  req_ready,
      input  get_enter, put_enter, del_enter,
      input  get_en, put_en, del_en,
      output get_cmd, put_cmd, del_cmd,
      output get_succ, put_succ, del_succ,
      input  resp_valid, resp_op, resp_succ, resp_err, busy,
      output resp_ready
   );

endinterface

// File: rtl/cache_ctrl_fsm_timeout_cnt.sv
// -----------------------------------------------------------------------------
// ctrl_timeout_cnt
// Saturating WAIT-cycle counter for the command sequencer.
//   clk, rst : parent clock / asynchronous active-high reset
//   clear    : reset count to 0 (has priority over inc)
//   inc      : count this cycle as a WAIT cycle without done
//   expired  : count has reached TIMEOUT_CYCLES, including the cycle whose
//              increment brings it there, so the parent can leave WAIT on
//              exactly the TIMEOUT_CYCLES-th idle WAIT cycle
// -----------------------------------------------------------------------------
module ctrl_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired = (r_cnt == LP_MAX) || (inc && (r_cnt == (LP_MAX - 1'b1)));

endmodule

// File: rtl/cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cache_ctrl_fsm
// Top-level command sequencer: accepts one GET/PUT/DEL/NOP request, kicks the
// matching sub-FSM with a one-cycle enter pulse, enables it until done (or a
// timeout), then returns one registered response.
//   clk, rst : clock / asynchronous active-high reset
//   bus      : cache_ctrl_fsm_if.master (request, sub-FSM links, response)
// -----------------------------------------------------------------------------
module cache_ctrl_fsm
   import ctrl_types_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   cache_ctrl_fsm_if.master  bus
);

   ctrl_state_e      r_state, w_state_next;
   op_e              r_op;
   logic             r_resp_valid;
   op_e              r_resp_op;
   logic             r_resp_succ;
   logic             r_resp_err;

   logic             w_clear, w_inc, w_expired;
   logic [N_SUB-1:0] w_sel, w_done, w_succ, w_enter, w_en;
   logic             w_sel_done, w_sel_succ;
   logic             w_unused_cmd;

   assign w_done = {bus.del_cmd.done, bus.put_cmd.done, bus.get_cmd.done};
   assign w_succ = {bus.del_succ, bus.put_succ, bus.get_succ};

   // Only done is consumed from the sub-FSM command words.
   assign w_unused_cmd = ^{bus.get_cmd, bus.put_cmd, bus.del_cmd};

   // One-hot decode of the latched op onto the sub-FSM ports.
   genvar gi;
   generate
      for (gi = 0; gi < N_SUB; gi++) begin : g_sub
         assign w_sel[gi]   = (2'(r_op) == 2'(gi + 1));
         assign w_enter[gi] = (r_state == CTRL_ST_DISPATCH) && w_sel[gi];
         assign w_en[gi]    = (r_state == CTRL_ST_WAIT) && w_sel[gi];
      end
   endgenerate

   // Non-selected done/succ never reach the FSM.
   assign w_sel_done = |(w_done & w_sel);
   assign w_sel_succ = |(w_succ & w_sel);

   ctrl_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (w_clear),
      .inc     (w_inc),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= CTRL_ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_inc        = 1'b0;
      case (r_state)
         CTRL_ST_IDLE: begin
            if (bus.req_valid) begin
               w_state_next = (bus.req_op == OP_NOP) ? CTRL_ST_RESP : CTRL_ST_DISPATCH;
            end
         end
         CTRL_ST_DISPATCH: begin
            w_clear      = 1'b1;
            w_state_next = CTRL_ST_WAIT;
         end
         CTRL_ST_WAIT: begin
            // done takes priority over a timeout landing in the same cycle
            if (w_sel_done) begin
               w_state_next = CTRL_ST_RESP;
            end else begin
               w_inc = 1'b1;
               if (w_expired) begin
                  w_state_next = CTRL_ST_RESP;
               end
            end
         end
         CTRL_ST_RESP: begin
            if (bus.resp_ready) begin
               w_state_next = CTRL_ST_IDLE;
            end
         end
         default: w_state_next = CTRL_ST_IDLE;
      endcase
   end

   // Op latch and response registers; resp_* only change on entry to RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op         <= OP_NOP;
         r_resp_valid <= 1'b0;
         r_resp_op    <= OP_NOP;
         r_resp_succ  <= 1'b0;
         r_resp_err   <= 1'b0;
      end else begin
         case (r_state)
            CTRL_ST_IDLE: begin
               if (bus.req_valid) begin
                  r_op <= bus.req_op;
                  if (bus.req_op == OP_NOP) begin
                     r_resp_valid <= 1'b1;
                     r_resp_op    <= OP_NOP;
                     r_resp_succ  <= 1'b1;
                     r_resp_err   <= 1'b0;
                  end
               end
            end
            CTRL_ST_WAIT: begin
               if (w_sel_done) begin
                  r_resp_valid <= 1'b1;
                  r_resp_op    <= r_op;
                  r_resp_succ  <= w_sel_succ;
                  r_resp_err   <= 1'b0;
               end else if (w_expired) begin
                  r_resp_valid <= 1'b1;
                  r_resp_op    <= r_op;
                  r_resp_succ  <= 1'b0;
                  r_resp_err   <= 1'b1;
               end
            end
            CTRL_ST_RESP: begin
               if (bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // req_ready is also gated by rst so it reads 0 while reset is held.
   assign bus.req_ready  = (r_state == CTRL_ST_IDLE) && !rst;
   assign bus.busy       = (r_state != CTRL_ST_IDLE);
   assign bus.get_enter  = w_enter[0];
   assign bus.put_enter  = w_enter[1];
   assign bus.del_enter  = w_enter[2];
   assign bus.get_en     = w_en[0];
   assign bus.put_en     = w_en[1];
   assign bus.del_en     = w_en[2];
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_op    = r_resp_op;
   assign bus.resp_succ  = r_resp_succ;
   assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl_fsm
// Directed plus randomized bench for cache_ctrl_fsm (TIMEOUT_CYCLES = 4).
// Sub-FSMs are stubbed: the selected one raises done on its d-th enabled
// cycle; the others toggle done/succ randomly and must be ignored.
// -----------------------------------------------------------------------------
module tb_cache_ctrl_fsm;
   import ctrl_types_pkg::*;

   localparam int T = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   cache_ctrl_fsm_if bus();

   cache_ctrl_fsm #(.TIMEOUT_CYCLES(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] enters();
      return {bus.del_enter, bus.put_enter, bus.get_enter};
   endfunction

   function automatic logic [2:0] ens();
      return {bus.del_en, bus.put_en, bus.get_en};
   endfunction

   function automatic logic [12:0] all_outs();
      return {bus.req_ready, enters(), ens(), bus.resp_valid, 2'(bus.resp_op),
              bus.resp_succ, bus.resp_err, bus.busy};
   endfunction

   task automatic drive_sub(input int idx, input logic done, input logic succ);
      case (idx)
         0: begin bus.get_cmd = '0; bus.get_cmd.done = done; bus.get_succ = succ; end
         1: begin bus.put_cmd = '0; bus.put_cmd.done = done; bus.put_succ = succ; end
         default: begin bus.del_cmd = '0; bus.del_cmd.done = done; bus.del_succ = succ; end
      endcase
   endtask

   task automatic clear_subs();
      for (int i = 0; i < 3; i++) drive_sub(i, 1'b0, 1'b0);
   endtask

   // One request/response. d = enabled cycle on which the selected sub-FSM
   // reports done (d > T means never). bp = cycles of resp_ready=0 after the
   // response appears. hold_next keeps a GET pending during backpressure.
   task automatic run_txn(input op_e op, input int d, input logic s, input int bp,
                          input bit hold_next, input string name);
      int exp_waits, exp_lat, sel, enter_cnt, enter_k, en_cnt, foreign, resp_k, cyc;
      logic exp_succ, exp_err, bp_ok;
      logic [2:0] ent, en;
      enter_cnt = 0; enter_k = -1; en_cnt = 0; foreign = 0; resp_k = -1; cyc = 0;
      bp_ok = 1'b1;
      // reference behaviour
      if (op == OP_NOP) begin
         exp_waits = 0; exp_lat = 1; exp_succ = 1'b1; exp_err = 1'b0; sel = -1;
      end else begin
         exp_waits = (d <= T) ? d : T;
         exp_lat   = 2 + exp_waits;
         exp_succ  = (d <= T) ? s : 1'b0;
         exp_err   = (d > T);
         sel       = int'(op) - 1;
      end

      bus.req_valid  = 1'b1;
      bus.req_op     = op;
      bus.resp_ready = 1'b0;
      chk({name, ".req_ready_idle"}, 32'(bus.req_ready), 1);
      @(posedge clk);
      for (int k = 1; k <= T + 12 && resp_k < 0; k++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         ent = enters();
         en  = ens();
         if (ent != 3'b000) begin
            if (sel >= 0 && ent == (3'b001 << sel)) begin enter_cnt++; enter_k = k; end
            else foreign++;
         end
         if (en != 3'b000) begin
            if (sel >= 0 && en == (3'b001 << sel)) begin en_cnt++; cyc++; end
            else foreign++;
         end
         for (int i = 0; i < 3; i++) begin
            if (i == sel) drive_sub(i, (en != 3'b000) && (cyc == d), s);
            else drive_sub(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         if (bus.resp_valid) resp_k = k;
      end
      clear_subs();

      chk({name, ".latency"}, 32'(resp_k), 32'(exp_lat));
      chk({name, ".resp_op"}, 32'(bus.resp_op), 32'(op));
      chk({name, ".resp_succ"}, 32'(bus.resp_succ), 32'(exp_succ));
      chk({name, ".resp_err"}, 32'(bus.resp_err), 32'(exp_err));
      chk({name, ".enter_cnt"}, 32'(enter_cnt), (op == OP_NOP) ? 0 : 1);
      if (op != OP_NOP) chk({name, ".enter_cycle"}, 32'(enter_k), 1);
      chk({name, ".en_cycles"}, 32'(en_cnt), 32'(exp_waits));
      chk({name, ".foreign_enter_en"}, 32'(foreign), 0);
      chk({name, ".req_ready_resp"}, 32'(bus.req_ready), 0);

      for (int i = 0; i < bp; i++) begin
         if (hold_next) begin bus.req_valid = 1'b1; bus.req_op = OP_GET; end
         @(posedge clk);
         @(negedge clk);
         if ({bus.resp_valid, 2'(bus.resp_op), bus.resp_succ, bus.resp_err, bus.req_ready}
             !== {1'b1, 2'(op), exp_succ, exp_err, 1'b0}) bp_ok = 1'b0;
      end
      if (bp > 0) chk({name, ".bp_stable"}, 32'(bp_ok), 1);

      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk({name, ".after_hs"}, {29'd0, bus.resp_valid, bus.busy, bus.req_ready}, 32'b001);
      $display("txn %s op=%0d d=%0d s=%0d lat=%0d succ=%0d err=%0d", name, op, d, s,
               resp_k, exp_succ, exp_err);
   endtask

   initial begin
      logic no_resp;
      bus.req_valid = 1'b0;
      bus.req_op = OP_NOP;
      bus.resp_ready = 1'b0;
      clear_subs();

      // reset held 3 cycles with a pending request
      #1 rst = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op = OP_GET;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("reset.outs%0d", i), 32'(all_outs()), 0);
      end
      bus.req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset.req_ready_after", {30'd0, bus.req_ready, bus.busy}, 32'b10);

      // directed scenarios
      run_txn(OP_GET, 1, 1'b1, 0, 1'b0, "get_hit");
      run_txn(OP_PUT, T + 5, 1'b1, 0, 1'b0, "put_timeout");
      run_txn(OP_DEL, T, 1'b0, 0, 1'b0, "del_done_at_timeout");
      run_txn(OP_PUT, 2, 1'b1, 5, 1'b1, "backpressure");
      run_txn(OP_GET, 3, 1'b0, 0, 1'b0, "held_get");

      // reset while in WAIT
      bus.req_valid = 1'b1;
      bus.req_op = OP_GET;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("midrst.en_before", 32'(bus.get_en), 1);
      rst = 1'b1;
      #1;
      chk("midrst.outs_during", 32'(all_outs()), 0);
      @(negedge clk);
      rst = 1'b0;
      no_resp = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b0) no_resp = 1'b0;
      end
      chk("midrst.no_resp", 32'(no_resp), 1);
      chk("midrst.req_ready", 32'(bus.req_ready), 1);
      run_txn(OP_NOP, 0, 1'b0, 0, 1'b0, "nop");

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         run_txn(op_e'($urandom_range(0, 3)), int'($urandom_range(1, T + 2)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0,
                 $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
